// File: rtl/spm_cmd_pkg.sv
// rtl/spm_cmd_pkg.sv - shared opcodes, response codes, FSM encoding and key sizing for the SM command sequencer
package spm_cmd_pkg;

   localparam int KEY_IDX_SIZE_DEF = 4;

   function automatic int nb_key_words(input int idx_size);
      return 2 ** idx_size;
   endfunction

   localparam int NB_KEY_WORDS = nb_key_words(KEY_IDX_SIZE_DEF);

   localparam logic [1:0] OP_PROTECT   = 2'b00;
   localparam logic [1:0] OP_UNPROTECT = 2'b01;
   localparam logic [1:0] OP_VERIFY    = 2'b10;
   localparam logic [1:0] OP_GET_ID    = 2'b11;

   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_VIOL    = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UPDATE = 3'd1,
      ST_VERIFY = 3'd2,
      ST_CHECK  = 3'd3,
      ST_HASH   = 3'd4,
      ST_KEY_WR = 3'd5,
      ST_RESP   = 3'd6
   } state_t;

endpackage

// File: rtl/omsp_spm_cmd_sequencer_if.sv
// rtl/omsp_spm_cmd_sequencer_if.sv - command, SPM control, hash key and response signals of the sequencer
interface omsp_spm_cmd_sequencer_if #(
   parameter int KEY_IDX_SIZE = 4
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [1:0]              cmd_op;
   logic                    violation;
   logic [15:0]             spm_current_id;
   logic                    update_spm;
   logic                    enable_spm;
   logic                    verify_spm;
   logic                    hash_start;
   logic                    hash_word_vld;
   logic [15:0]             hash_word;
   logic                    hash_word_rdy;
   logic                    write_key;
   logic [15:0]             key_in;
   logic [KEY_IDX_SIZE-1:0] key_idx;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [1:0]              rsp_status;
   logic [15:0]             rsp_id;

   modport slave (
      input  cmd_valid, cmd_op, violation, spm_current_id, hash_word_vld, hash_word, rsp_ready,
      output cmd_ready, update_spm, enable_spm, verify_spm, hash_start, hash_word_rdy,
             write_key, key_in, key_idx, rsp_valid, rsp_status, rsp_id
   );

   modport master (
      output cmd_valid, cmd_op, violation, spm_current_id, hash_word_vld, hash_word, rsp_ready,
      input  cmd_ready, update_spm, enable_spm, verify_spm, hash_start, hash_word_rdy,
             write_key, key_in, key_idx, rsp_valid, rsp_status, rsp_id
   );
endinterface

// File: rtl/omsp_spm_key_loader.sv
// rtl/omsp_spm_key_loader.sv - key word handshake, key_idx counter, last-word flag, optional watchdog (SPM_CMD_TIMEOUT_EN)
module omsp_spm_key_loader
   import spm_cmd_pkg::*;
#(
   parameter int KEY_IDX_SIZE   = KEY_IDX_SIZE_DEF,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clear,
   input  logic                    i_active,
   input  logic                    i_word_vld,
   input  logic [15:0]             i_word,
   output logic                    o_word_rdy,
   output logic                    o_write_key,
   output logic [15:0]             o_key_in,
   output logic [KEY_IDX_SIZE-1:0] o_key_idx,
   output logic                    o_last,
   output logic                    o_timeout
);
   localparam int NB = nb_key_words(KEY_IDX_SIZE);

   logic [KEY_IDX_SIZE-1:0] r_cnt;
   logic                    w_accept;

   assign w_accept    = i_active & i_word_vld;
   assign o_word_rdy  = i_active;
   assign o_write_key = w_accept;
   assign o_key_in    = w_accept ? i_word : 16'h0000;
   assign o_key_idx   = w_accept ? r_cnt : '0;
   assign o_last      = w_accept && (r_cnt == KEY_IDX_SIZE'(NB - 1));

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

`ifdef SPM_CMD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   // r_wdog = cycles elapsed since hash_start or the last accepted word
   logic [WD_W-1:0] r_wdog;

   assign o_timeout = i_active && !w_accept && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog <= '0;
      end else if (i_clear || w_accept) begin
         r_wdog <= WD_W'(1);
      end else if (i_active) begin
         r_wdog <= r_wdog + WD_W'(1);
      end
   end
`else
   // watchdog compiled out; the limit only ties the flag low
   assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: rtl/omsp_spm_cmd_sequencer.sv
// rtl/omsp_spm_cmd_sequencer.sv - Sancus SM command sequencer: FSM, SPM pulses, response register (SPM_CMD_TIMEOUT_EN)
module omsp_spm_cmd_sequencer
   import spm_cmd_pkg::*;
#(
   parameter int KEY_IDX_SIZE   = KEY_IDX_SIZE_DEF,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                     mclk,
   input logic                     puc_rst,
   omsp_spm_cmd_sequencer_if.slave bus
);
   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_op;
   logic [1:0]  r_rsp_status;
   logic [1:0]  w_status_nxt;
   logic [15:0] r_rsp_id;
   logic [15:0] w_id_nxt;
   logic        w_rsp_load;
   logic        w_accept;
   logic        w_last;
   logic        w_timeout;

   assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;

   omsp_spm_key_loader #(
      .KEY_IDX_SIZE   (KEY_IDX_SIZE),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_key_loader (
      .clk         (mclk),
      .rst         (puc_rst),
      .i_clear     (r_state == ST_HASH),
      .i_active    (r_state == ST_KEY_WR),
      .i_word_vld  (bus.hash_word_vld),
      .i_word      (bus.hash_word),
      .o_word_rdy  (bus.hash_word_rdy),
      .o_write_key (bus.write_key),
      .o_key_in    (bus.key_in),
      .o_key_idx   (bus.key_idx),
      .o_last      (w_last),
      .o_timeout   (w_timeout)
   );

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         r_state      <= ST_IDLE;
         r_op         <= OP_PROTECT;
         r_rsp_status <= RSP_OK;
         r_rsp_id     <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op <= bus.cmd_op;
         end
         if (w_rsp_load) begin
            r_rsp_status <= w_status_nxt;
            r_rsp_id     <= w_id_nxt;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_rsp_load     = 1'b0;
      w_status_nxt   = RSP_OK;
      w_id_nxt       = 16'h0000;
      bus.cmd_ready  = 1'b0;
      bus.update_spm = 1'b0;
      bus.enable_spm = 1'b0;
      bus.verify_spm = 1'b0;
      bus.hash_start = 1'b0;
      bus.rsp_valid  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_PROTECT, OP_UNPROTECT: w_state_nxt = ST_UPDATE;
                  OP_VERIFY:                w_state_nxt = ST_VERIFY;
                  default: begin
                     w_state_nxt = ST_RESP;
                     w_rsp_load  = 1'b1;
                     w_id_nxt    = bus.spm_current_id;
                  end
               endcase
            end
         end
         ST_UPDATE: begin
            bus.update_spm = 1'b1;
            bus.enable_spm = (r_op == OP_PROTECT);
            if (r_op == OP_PROTECT) begin
               w_state_nxt = ST_CHECK;
            end else begin
               w_state_nxt = ST_RESP;
               w_rsp_load  = 1'b1;
            end
         end
         ST_VERIFY: begin
            bus.verify_spm = 1'b1;
            w_state_nxt    = ST_CHECK;
         end
         ST_CHECK: begin
            if (bus.violation) begin
               w_state_nxt  = ST_RESP;
               w_rsp_load   = 1'b1;
               w_status_nxt = RSP_VIOL;
            end else if (r_op == OP_PROTECT) begin
               w_state_nxt = ST_HASH;
            end else begin
               w_state_nxt = ST_RESP;
               w_rsp_load  = 1'b1;
            end
         end
         ST_HASH: begin
            bus.hash_start = 1'b1;
            w_state_nxt    = ST_KEY_WR;
         end
         ST_KEY_WR: begin
            // a stalled key derivation tears the half-created module down
            bus.update_spm = w_timeout;
            if (w_last) begin
               w_state_nxt = ST_RESP;
               w_rsp_load  = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt  = ST_RESP;
               w_rsp_load   = 1'b1;
               w_status_nxt = RSP_TIMEOUT;
            end
         end
         ST_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.rsp_status = r_rsp_status;
   assign bus.rsp_id     = r_rsp_id;

endmodule
